// File: rtl/collatz_trace_reader_pkg.sv
// Shared definitions for the Collatz trace reader: widths, state encoding and the step rule.
// The step rule is also the golden model for the datapath microcode bench.
package collatz_trace_reader_pkg;

    localparam int unsigned DATAWIDTH_BUS   = 8;
    localparam int unsigned DATAWIDTH_SEED  = 6;
    localparam int unsigned DATAWIDTH_STEPS = 8;
    localparam int unsigned TIMEOUT_CYCLES  = 1024;
    localparam int unsigned TIMER_W         = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned WIDE_W          = DATAWIDTH_BUS + 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_TRACK = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAIL  = 3'd4
    } state_t;

    typedef struct packed {
        logic [DATAWIDTH_BUS-1:0] next;
        logic                     ovf;
    } step_t;

    // Even n halves; odd n becomes 3n+1 built as n + 2n + 1, truncated to the bus width.
    function automatic step_t collatz_step(input logic [DATAWIDTH_BUS-1:0] n);
        logic [WIDE_W-1:0] tn;
        step_t             r;
        tn = {2'b00, n} + {1'b0, n, 1'b0} + WIDE_W'(1);
        if (n[0]) begin
            r.next = tn[DATAWIDTH_BUS-1:0];
            r.ovf  = |tn[WIDE_W-1:DATAWIDTH_BUS];
        end else begin
            r.next = n >> 1;
            r.ovf  = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/collatz_trace_reader_next_value.sv
// Combinational Collatz step: next value of n and a flag when 3n+1 does not fit the bus.
module collatz_next_value
    import collatz_trace_reader_pkg::*;
(
    input  logic [DATAWIDTH_BUS-1:0] n,
    output logic [DATAWIDTH_BUS-1:0] next,
    output logic                     ovf
);

    step_t step;

    assign step = collatz_step(n);
    assign next = step.next;
    assign ovf  = step.ovf;

endmodule

// File: rtl/collatz_trace_reader.sv
// Follows the Collatz datapath result bus from a known seed, checking every new value
// against a locally computed reference step; reports done, mismatch, overflow or timeout.
module collatz_trace_reader
    import collatz_trace_reader_pkg::*;
(
    input  logic                       TRACEREADER_CLOCK_50,
    input  logic                       TRACEREADER_RESET_InHigh,
    input  logic                       TRACEREADER_start_InHigh,
    input  logic [DATAWIDTH_SEED-1:0]  TRACEREADER_seed_InBUS,
    input  logic [DATAWIDTH_BUS-1:0]   TRACEREADER_data_InBUS,
    input  logic                       TRACEREADER_ack_InHigh,
    output logic                       TRACEREADER_busy_OutHigh,
    output logic                       TRACEREADER_done_OutHigh,
    output logic                       TRACEREADER_fail_OutHigh,
    output logic                       TRACEREADER_timeout_OutHigh,
    output logic                       TRACEREADER_overflow_OutHigh,
    output logic [DATAWIDTH_STEPS-1:0] TRACEREADER_steps_OutBUS,
    output logic [DATAWIDTH_BUS-1:0]   TRACEREADER_peak_OutBUS,
    output logic [DATAWIDTH_BUS-1:0]   TRACEREADER_badvalue_OutBUS
);

    logic clk, rst, start, ack;
    assign clk   = TRACEREADER_CLOCK_50;
    assign rst   = TRACEREADER_RESET_InHigh;
    assign start = TRACEREADER_start_InHigh;
    assign ack   = TRACEREADER_ack_InHigh;

    state_t                     state, state_d;
    logic [DATAWIDTH_BUS-1:0]   sample, prev;
    logic [DATAWIDTH_BUS-1:0]   expected, expected_d;
    logic [TIMER_W-1:0]         timer, timer_d;
    logic                       busy, busy_d, done, done_d, fail, fail_d;
    logic                       timeout, timeout_d, overflow, overflow_d;
    logic [DATAWIDTH_STEPS-1:0] steps, steps_d;
    logic [DATAWIDTH_BUS-1:0]   peak, peak_d, badvalue, badvalue_d;
    logic [DATAWIDTH_BUS-1:0]   next_val;
    logic                       next_ovf;
    logic [DATAWIDTH_BUS-1:0]   seed_ext;
    logic                       change_c, timer_expired_c;

    collatz_next_value u_next (
        .n    (expected),
        .next (next_val),
        .ovf  (next_ovf)
    );

    assign seed_ext        = DATAWIDTH_BUS'(TRACEREADER_seed_InBUS);
    assign change_c        = (sample != prev);
    assign timer_expired_c = (timer == TIMER_W'(TIMEOUT_CYCLES - 1));

    // Bus sampling and all state/output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            sample   <= '0;
            prev     <= '0;
            expected <= '0;
            timer    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            fail     <= 1'b0;
            timeout  <= 1'b0;
            overflow <= 1'b0;
            steps    <= '0;
            peak     <= '0;
            badvalue <= '0;
        end else begin
            state    <= state_d;
            sample   <= TRACEREADER_data_InBUS;
            prev     <= sample;
            expected <= expected_d;
            timer    <= timer_d;
            busy     <= busy_d;
            done     <= done_d;
            fail     <= fail_d;
            timeout  <= timeout_d;
            overflow <= overflow_d;
            steps    <= steps_d;
            peak     <= peak_d;
            badvalue <= badvalue_d;
        end
    end

    // Next-state and next-output logic; start overrides everything else.
    always_comb begin
        state_d    = state;
        expected_d = expected;
        timer_d    = timer;
        done_d     = done;
        fail_d     = fail;
        timeout_d  = timeout;
        overflow_d = overflow;
        steps_d    = steps;
        peak_d     = peak;
        badvalue_d = badvalue;

        if (start) begin
            state_d    = ST_SYNC;
            expected_d = seed_ext;
            timer_d    = '0;
            done_d     = 1'b0;
            fail_d     = 1'b0;
            timeout_d  = 1'b0;
            overflow_d = 1'b0;
            steps_d    = '0;
            peak_d     = seed_ext;
            badvalue_d = '0;
        end else begin
            unique case (state)
                ST_IDLE: ;
                ST_SYNC: begin
                    if (sample == expected) begin
                        timer_d = '0;
                        if (expected == DATAWIDTH_BUS'(1)) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d    = ST_TRACK;
                            expected_d = next_val;
                            overflow_d = overflow | next_ovf;
                        end
                    end else if (timer_expired_c) begin
                        state_d   = ST_FAIL;
                        fail_d    = 1'b1;
                        timeout_d = 1'b1;
                    end else begin
                        timer_d = timer + TIMER_W'(1);
                    end
                end
                ST_TRACK: begin
                    if (change_c) begin
                        if (sample == expected) begin
                            timer_d = '0;
                            if (steps != '1) begin
                                steps_d = steps + DATAWIDTH_STEPS'(1);
                            end
                            peak_d = (sample > peak) ? sample : peak;
                            if (sample == DATAWIDTH_BUS'(1)) begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                            end else begin
                                expected_d = next_val;
                                overflow_d = overflow | next_ovf;
                            end
                        end else begin
                            state_d    = ST_FAIL;
                            fail_d     = 1'b1;
                            badvalue_d = sample;
                        end
                    end else if (timer_expired_c) begin
                        state_d   = ST_FAIL;
                        fail_d    = 1'b1;
                        timeout_d = 1'b1;
                    end else begin
                        timer_d = timer + TIMER_W'(1);
                    end
                end
                ST_DONE, ST_FAIL: begin
                    if (ack) begin
                        state_d    = ST_IDLE;
                        done_d     = 1'b0;
                        fail_d     = 1'b0;
                        timeout_d  = 1'b0;
                        badvalue_d = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d == ST_SYNC) || (state_d == ST_TRACK);
    end

    assign TRACEREADER_busy_OutHigh     = busy;
    assign TRACEREADER_done_OutHigh     = done;
    assign TRACEREADER_fail_OutHigh     = fail;
    assign TRACEREADER_timeout_OutHigh  = timeout;
    assign TRACEREADER_overflow_OutHigh = overflow;
    assign TRACEREADER_steps_OutBUS     = steps;
    assign TRACEREADER_peak_OutBUS      = peak;
    assign TRACEREADER_badvalue_OutBUS  = badvalue;

endmodule

// File: tb/tb_collatz_trace_reader.sv
// Directed bench for collatz_trace_reader: hand-computed traces, mismatch, timeout, reset and ack cases.
module tb_collatz_trace_reader;

    logic       clk = 1'b0;
    logic       rst, start, ack;
    logic [5:0] seed;
    logic [7:0] data;
    logic       busy, done, fail, timeout, overflow;
    logic [7:0] steps, peak, badvalue;

    int vectors     = 0;
    int miscompares = 0;

    // Truncated 8-bit trace from seed 27 (107 -> 66 is where 3n+1 wraps).
    logic [7:0] s27 [39] = '{82, 41, 124, 62, 31, 94, 47, 142, 71, 214, 107, 66,
                             33, 100, 50, 25, 76, 38, 19, 58, 29, 88, 44, 22, 11,
                             34, 17, 52, 26, 13, 40, 20, 10, 5, 16, 8, 4, 2, 1};
    logic [7:0] s6  [8]  = '{3, 10, 5, 16, 8, 4, 2, 1};

    collatz_trace_reader dut (
        .TRACEREADER_CLOCK_50         (clk),
        .TRACEREADER_RESET_InHigh     (rst),
        .TRACEREADER_start_InHigh     (start),
        .TRACEREADER_seed_InBUS       (seed),
        .TRACEREADER_data_InBUS       (data),
        .TRACEREADER_ack_InHigh       (ack),
        .TRACEREADER_busy_OutHigh     (busy),
        .TRACEREADER_done_OutHigh     (done),
        .TRACEREADER_fail_OutHigh     (fail),
        .TRACEREADER_timeout_OutHigh  (timeout),
        .TRACEREADER_overflow_OutHigh (overflow),
        .TRACEREADER_steps_OutBUS     (steps),
        .TRACEREADER_peak_OutBUS      (peak),
        .TRACEREADER_badvalue_OutBUS  (badvalue)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [5:0] s, input logic [7:0] d);
        start = 1'b1;
        seed  = s;
        data  = d;
        tick(1);
        start = 1'b0;
    endtask

    task automatic feed(input logic [7:0] v, input int hold);
        data = v;
        tick(hold);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ack = 1'b0; seed = '0; data = '0;
        tick(2);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_fail", 32'(fail), 0);
        chk("rst_steps", 32'(steps), 0);
        chk("rst_peak", 32'(peak), 0);
        chk("rst_badvalue", 32'(badvalue), 0);
        rst = 1'b0;
        tick(1);

        // Seed 6, each value held 5 cycles.
        do_start(6, 6);
        chk("s6_busy", 32'(busy), 1);
        feed(6, 5);
        for (int i = 0; i < 8; i++) feed(s6[i], 5);
        chk("s6_done", 32'(done), 1);
        chk("s6_fail", 32'(fail), 0);
        chk("s6_steps", 32'(steps), 8);
        chk("s6_peak", 32'(peak), 16);
        chk("s6_overflow", 32'(overflow), 0);
        chk("s6_busy_end", 32'(busy), 0);

        do_ack();
        chk("ack_done", 32'(done), 0);
        chk("ack_busy", 32'(busy), 0);
        chk("ack_steps_kept", 32'(steps), 8);
        chk("ack_peak_kept", 32'(peak), 16);

        // Seed 1: one cycle in SYNC, then DONE.
        do_start(1, 1);
        chk("s1_sync_done", 32'(done), 0);
        tick(1);
        chk("s1_done", 32'(done), 1);
        chk("s1_steps", 32'(steps), 0);
        chk("s1_peak", 32'(peak), 1);
        do_ack();

        // Mismatch: 11 where 10 is expected.
        do_start(6, 6);
        feed(6, 3);
        feed(3, 3);
        feed(11, 3);
        chk("mm_fail", 32'(fail), 1);
        chk("mm_timeout", 32'(timeout), 0);
        chk("mm_badvalue", 32'(badvalue), 11);
        chk("mm_steps", 32'(steps), 1);
        chk("mm_peak", 32'(peak), 6);
        chk("mm_done", 32'(done), 0);

        // Start and ack together in FAIL restarts with seed 27.
        ack = 1'b1;
        do_start(27, 27);
        ack = 1'b0;
        chk("sa_busy", 32'(busy), 1);
        chk("sa_fail", 32'(fail), 0);
        chk("sa_badvalue", 32'(badvalue), 0);
        chk("sa_steps", 32'(steps), 0);
        chk("sa_peak", 32'(peak), 27);
        feed(27, 2);
        for (int i = 0; i < 10; i++) feed(s27[i], 2);
        chk("s27_steps10", 32'(steps), 10);
        chk("s27_ovf_before", 32'(overflow), 0);
        feed(s27[10], 2);
        chk("s27_ovf_set", 32'(overflow), 1);
        do_ack();
        chk("busy_ack_ignored", 32'(busy), 1);
        for (int i = 11; i < 39; i++) feed(s27[i], 2);
        chk("s27_done", 32'(done), 1);
        chk("s27_fail", 32'(fail), 0);
        chk("s27_steps", 32'(steps), 39);
        chk("s27_peak", 32'(peak), 214);
        chk("s27_overflow", 32'(overflow), 1);
        do_ack();

        // Timeout: bus frozen at 3 after it was accepted.
        do_start(6, 6);
        tick(1);
        feed(3, 2);
        chk("to_steps", 32'(steps), 1);
        tick(1023);
        chk("to_not_yet", 32'(fail), 0);
        chk("to_busy", 32'(busy), 1);
        tick(1);
        chk("to_fail", 32'(fail), 1);
        chk("to_timeout", 32'(timeout), 1);
        chk("to_busy_end", 32'(busy), 0);
        do_ack();
        chk("to_ack_timeout", 32'(timeout), 0);

        // Reset during TRACK after three steps.
        do_start(6, 6);
        feed(6, 2);
        feed(3, 2);
        feed(10, 2);
        feed(5, 2);
        chk("mr_steps_pre", 32'(steps), 3);
        #2 rst = 1'b1;
        #1;
        chk("mr_busy", 32'(busy), 0);
        chk("mr_steps", 32'(steps), 0);
        chk("mr_peak", 32'(peak), 0);
        tick(1);
        rst = 1'b0;
        do_start(5, 5);
        feed(5, 2);
        feed(16, 2);
        feed(8, 2);
        feed(4, 2);
        feed(2, 2);
        feed(1, 2);
        chk("s5_done", 32'(done), 1);
        chk("s5_steps", 32'(steps), 5);
        chk("s5_peak", 32'(peak), 16);
        chk("s5_overflow", 32'(overflow), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
